// File: rtl/timer_apb_sequencer.sv
// APB master that runs a whole timer session: program TDR/TCR, poll TSR, clear, stop.
// Optional poll timeout is built when TIMER_SEQ_TIMEOUT_EN is defined.
module timer_apb_sequencer #(
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_load,
    input  logic [1:0] cmd_cks,
    input  logic       cmd_down,
    input  logic       cmd_abort,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [7:0] m_paddr,
    output logic       m_psel,
    output logic       m_penable,
    output logic       m_pwrite,
    output logic [7:0] m_pwdata,
    input  logic [7:0] m_prdata,
    input  logic       m_pready,
    input  logic       m_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_RUN,
        S_POLL, S_GAP, S_CLR, S_STOP
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP, PH_ACCESS, PH_END
    } phase_e;

    localparam logic [7:0] A_TDR = 8'h00;
    localparam logic [7:0] A_TCR = 8'h01;
    localparam logic [7:0] A_TSR = 8'h02;

    state_e     state_q, state_d, nxt;
    phase_e     phase_q, phase_d;
    logic [7:0] load_q, load_d;
    logic [1:0] cks_q, cks_d;
    logic       down_q, down_d;
    logic       abort_q, abort_d;
    logic       flag_q, flag_d;
    logic [7:0] gap_q, gap_d;
    logic       tmo_hit;
    logic       bus_st;
    logic       stop_now;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= S_IDLE;
            phase_q <= PH_SETUP;
            load_q  <= '0;
            cks_q   <= '0;
            down_q  <= 1'b0;
            abort_q <= 1'b0;
            flag_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            load_q  <= load_d;
            cks_q   <= cks_d;
            down_q  <= down_d;
            abort_q <= abort_d;
            flag_q  <= flag_d;
            gap_q   <= gap_d;
        end
    end

`ifdef TIMER_SEQ_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        polling;

    assign polling = (state_q == S_POLL) || (state_q == S_GAP);
    assign tmo_hit = polling && (tmo_q >= 16'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_WR_RUN) begin
            tmo_d = '0;
        end else if (polling && !tmo_hit) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^16'(TIMEOUT_CYCLES);
`endif

    logic unused_rd;
    assign unused_rd = ^m_prdata[7:2];

    // an abort raised this very cycle must still redirect the next transfer
    assign stop_now = abort_q | cmd_abort | tmo_hit;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        load_d    = load_q;
        cks_d     = cks_q;
        down_d    = down_q;
        flag_d    = flag_q;
        gap_d     = 8'd0;
        abort_d   = abort_q | ((state_q != S_IDLE) & (cmd_abort | tmo_hit));
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        m_paddr   = 8'h00;
        m_pwrite  = 1'b0;
        m_pwdata  = 8'h00;
        nxt       = S_IDLE;
        bus_st    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                bus_st = 1'b0;
                if (cmd_valid) begin
                    load_d  = cmd_load;
                    cks_d   = cmd_cks;
                    down_d  = cmd_down;
                    abort_d = 1'b0;
                    flag_d  = 1'b0;
                    phase_d = PH_SETUP;
                    state_d = S_WR_TDR;
                end
            end
            S_WR_TDR: begin
                m_paddr  = A_TDR;
                m_pwrite = 1'b1;
                m_pwdata = load_q;
                nxt      = S_WR_LOAD;
            end
            S_WR_LOAD: begin
                m_paddr  = A_TCR;
                m_pwrite = 1'b1;
                m_pwdata = {1'b1, 1'b0, down_q, 1'b0, 2'b00, cks_q};
                nxt      = S_WR_RUN;
            end
            S_WR_RUN: begin
                m_paddr  = A_TCR;
                m_pwrite = 1'b1;
                m_pwdata = {1'b0, 1'b0, down_q, 1'b1, 2'b00, cks_q};
                nxt      = S_POLL;
            end
            S_POLL: begin
                m_paddr = A_TSR;
                if (flag_q) begin
                    nxt = S_CLR;
                end else if (POLL_GAP == 0) begin
                    nxt = S_POLL;
                end else begin
                    nxt = S_GAP;
                end
            end
            S_GAP: begin
                bus_st = 1'b0;
                gap_d  = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
                if (stop_now) begin
                    state_d = S_STOP;
                end else if (({24'd0, gap_q} + 32'd1) >= POLL_GAP) begin
                    state_d = S_POLL;
                end
            end
            S_CLR: begin
                m_paddr  = A_TSR;
                m_pwrite = 1'b1;
                nxt      = S_STOP;
            end
            S_STOP: begin
                m_paddr  = A_TCR;
                m_pwrite = 1'b1;
                nxt      = S_IDLE;
            end
        endcase

        m_psel    = bus_st && (phase_q != PH_END);
        m_penable = bus_st && (phase_q == PH_ACCESS);

        // PH_END is the idle cycle after pready where the next step is chosen
        if (bus_st) begin
            unique case (phase_q)
                PH_SETUP: phase_d = PH_ACCESS;
                PH_ACCESS: begin
                    if (m_pready) begin
                        phase_d = PH_END;
                        if (m_pslverr) begin
                            abort_d = 1'b1;
                        end
                        if (state_q == S_POLL) begin
                            flag_d = down_q ? m_prdata[1] : m_prdata[0];
                        end
                    end
                end
                PH_END: begin
                    phase_d = PH_SETUP;
                    if (state_q == S_STOP) begin
                        done    = 1'b1;
                        err     = abort_q;
                        state_d = S_IDLE;
                    end else if (stop_now) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = nxt;
                    end
                end
                default: phase_d = PH_SETUP;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench for timer_apb_sequencer with an APB timer slave model and a
// transaction-level scoreboard checked every cycle.
module tb_timer_apb_sequencer;

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_load;
    logic [1:0] cmd_cks;
    logic       cmd_down, cmd_abort;
    logic       done, err, busy;
    logic [7:0] m_paddr, m_pwdata, m_prdata;
    logic       m_psel, m_penable, m_pwrite, m_pready, m_pslverr;

    always #5 pclk = ~pclk;

    timer_apb_sequencer #(
        .POLL_GAP      (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_cks   (cmd_cks),
        .cmd_down  (cmd_down),
        .cmd_abort (cmd_abort),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- timer slave model ----------------
    logic [7:0] tdr = 0, tcr = 0, cnt = 0, tsr = 0;
    int         presc = 0, acc_cnt = 0, cur_waits = 0;
    int         waits_tdr = 0;
    bit         err_on_run = 0, tsr_stuck = 0;
    bit         comp_prev = 0, c_wr = 0;
    logic [7:0] c_addr = 0, c_wdata = 0;

    initial begin
        m_pready  = 1'b0;
        m_prdata  = 8'h00;
        m_pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (comp_prev && c_wr) begin
                case (c_addr)
                    8'h00: tdr = c_wdata;
                    8'h01: begin
                        tcr   = c_wdata;
                        presc = 0;
                        if (c_wdata[7]) cnt = tdr;
                    end
                    8'h02: tsr = tsr & c_wdata;
                    default: ;
                endcase
            end
            if (tcr[4]) begin
                presc++;
                if (presc >= (2 << tcr[1:0])) begin
                    presc = 0;
                    if (tcr[5]) begin
                        if (cnt == 8'h00) tsr[1] = 1'b1;
                        cnt = cnt - 8'd1;
                    end else begin
                        if (cnt == 8'hFF) tsr[0] = 1'b1;
                        cnt = cnt + 8'd1;
                    end
                end
            end
            if (m_psel && m_penable) begin
                acc_cnt++;
                cur_waits = (m_paddr == 8'h00 && m_pwrite) ? waits_tdr : 0;
                m_pready  = (acc_cnt > cur_waits);
                m_prdata  = (m_paddr == 8'h02 && !tsr_stuck) ? tsr : 8'h00;
                m_pslverr = m_pready && err_on_run && m_pwrite &&
                            (m_paddr == 8'h01) && m_pwdata[4];
            end else begin
                acc_cnt   = 0;
                m_pready  = 1'b0;
                m_prdata  = 8'h00;
                m_pslverr = 1'b0;
            end
            comp_prev = m_psel && m_penable && m_pready;
            c_wr      = m_pwrite;
            c_addr    = m_paddr;
            c_wdata   = m_pwdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
        bit         poll;
    } xfer_t;

    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
        int         len;
        int         cyc;
    } rec_t;

    xfer_t      exp_q[$];
    rec_t       log_q[$];
    bit         aborted = 0, in_sess = 0, done_pend = 0, prev_psel = 0;
    bit         cur_poll = 0, cur_stop = 0, tgt_down = 0;
    logic [7:0] h_addr = 0, h_wdata = 0;
    logic       h_wr = 0;
    int         acc_len = 0, cyc = 0, done_cnt = 0;
    logic       last_err = 0;

    function automatic xfer_t mk(logic [7:0] a, logic w, logic [7:0] d, bit p);
        xfer_t x;
        x.a = a; x.w = w; x.d = d; x.poll = p;
        return x;
    endfunction

    always @(negedge pclk) begin
        cyc++;
        if (preset) begin
            exp_q.delete();
            aborted   = 0;
            in_sess   = 0;
            done_pend = 0;
            prev_psel = 0;
        end else begin
            chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            chk("done", 32'(done), 32'(done_pend));
            if (done_pend) begin
                chk("err", 32'(err), 32'(aborted));
                last_err  = err;
                done_cnt++;
                done_pend = 0;
                in_sess   = 0;
            end
            if (m_psel && !m_penable) begin
                xfer_t e;
                e = mk(8'h01, 1'b1, 8'h00, 1'b0);
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_xfer: got addr %0h want none",
                                 m_paddr);
                    end else begin
                        e = exp_q.pop_front();
                    end
`ifdef TIMER_SEQ_TIMEOUT_EN
                    // the timeout is invisible on the bus: STOP replacing a poll
                    if (e.poll && m_pwrite && m_paddr == 8'h01) begin
                        aborted = 1;
                        e = mk(8'h01, 1'b1, 8'h00, 1'b0);
                    end
`endif
                end
                if (aborted) exp_q.delete();
                chk("setup_addr", 32'(m_paddr), 32'(e.a));
                chk("setup_write", 32'(m_pwrite), 32'(e.w));
                if (e.w) chk("setup_wdata", 32'(m_pwdata), 32'(e.d));
                cur_poll = e.poll;
                cur_stop = (e.a == 8'h01 && e.w && e.d == 8'h00);
                h_addr   = m_paddr;
                h_wr     = m_pwrite;
                h_wdata  = m_pwdata;
                acc_len  = 0;
            end
            if (m_penable) begin
                chk("penable_needs_psel", 32'(m_psel), 32'd1);
                chk("setup_before_access", 32'(prev_psel), 32'd1);
                chk("stable", {15'd0, m_paddr, m_pwrite, m_pwdata},
                    {15'd0, h_addr, h_wr, h_wdata});
                acc_len++;
                if (m_pready) begin
                    rec_t r;
                    chk("access_len", 32'(acc_len), 32'(cur_waits + 1));
                    r.a = m_paddr; r.w = m_pwrite;
                    r.d = m_pwrite ? m_pwdata : m_prdata;
                    r.len = acc_len; r.cyc = cyc;
                    log_q.push_back(r);
                    if (m_pslverr) aborted = 1;
                    if (cur_poll && !aborted) begin
                        if (tgt_down ? m_prdata[1] : m_prdata[0]) begin
                            exp_q.push_back(mk(8'h02, 1'b1, 8'h00, 1'b0));
                            exp_q.push_back(mk(8'h01, 1'b1, 8'h00, 1'b0));
                        end else begin
                            exp_q.push_back(mk(8'h02, 1'b0, 8'h00, 1'b1));
                        end
                    end
                    if (cur_stop) done_pend = 1;
                end
            end
            if (in_sess && cmd_abort) aborted = 1;
            if (cmd_valid && cmd_ready) begin
                exp_q.delete();
                exp_q.push_back(mk(8'h00, 1'b1, cmd_load, 1'b0));
                exp_q.push_back(mk(8'h01, 1'b1,
                                   {2'b10, cmd_down, 3'b000, cmd_cks}, 1'b0));
                exp_q.push_back(mk(8'h01, 1'b1,
                                   {2'b00, cmd_down, 3'b100, cmd_cks}, 1'b0));
                exp_q.push_back(mk(8'h02, 1'b0, 8'h00, 1'b1));
                aborted  = 0;
                in_sess  = 1;
                tgt_down = cmd_down;
            end
            prev_psel = m_psel;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [7:0] ld, input logic [1:0] ck, input logic dn);
        for (int i = 0; i < 200 && !cmd_ready; i++) @(posedge pclk);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_cks   = ck;
        cmd_down  = dn;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 5000 && done_cnt == base; i++) @(posedge pclk);
        chk("done_seen", 32'(done_cnt != base), 32'd1);
        @(posedge pclk);
        #1;
    endtask

    task automatic session(input logic [7:0] ld, input logic [1:0] ck, input logic dn);
        int base;
        base = done_cnt;
        log_q.delete();
        issue(ld, ck, dn);
        wait_done(base);
    endtask

    function automatic bit has_tsr_read();
        foreach (log_q[i]) if (log_q[i].a == 8'h02 && !log_q[i].w) return 1;
        return 0;
    endfunction

    initial begin
        int base, n, run_cyc, stop_cyc;
        bit saw;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 8'h00;
        cmd_cks   = 2'b00;
        cmd_down  = 1'b0;
        cmd_abort = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outs", {23'd0, busy, done, err, m_psel, m_penable, m_pwrite,
                         m_paddr != 0, m_pwdata != 0}, 32'd0);
        @(posedge pclk);
        #1;
        preset = 1'b0;

        // count up, F0, /2
        session(8'hF0, 2'b00, 1'b0);
        n = log_q.size();
        chk("up_err", 32'(last_err), 32'd0);
        chk("up_tdr", {23'd0, log_q[0].a, log_q[0].d}, 32'h00F0);
        chk("up_load", {23'd0, log_q[1].a, log_q[1].d}, 32'h0180);
        chk("up_run", {23'd0, log_q[2].a, log_q[2].d}, 32'h0110);
        chk("up_last_tsr", {23'd0, log_q[n-3].a, log_q[n-3].d}, 32'h0201);
        chk("up_clr", {23'd0, log_q[n-2].a, log_q[n-2].d}, 32'h0200);
        chk("up_stop", {23'd0, log_q[n-1].a, log_q[n-1].d}, 32'h0100);
        chk("up_ready_after", 32'(cmd_ready), 32'd1);

        // count down, 10, /16
        session(8'h10, 2'b11, 1'b1);
        n = log_q.size();
        chk("dn_err", 32'(last_err), 32'd0);
        chk("dn_load", 32'(log_q[1].d), 32'hA3);
        chk("dn_run", 32'(log_q[2].d), 32'h33);
        chk("dn_flag", 32'(log_q[n-3].d[1]), 32'd1);

        // three wait states on the TDR write
        waits_tdr = 3;
        session(8'hFE, 2'b00, 1'b0);
        waits_tdr = 0;
        chk("ws_len", 32'(log_q[0].len), 32'd4);
        chk("ws_err", 32'(last_err), 32'd0);

        // slave error on WR_RUN
        err_on_run = 1;
        session(8'h40, 2'b01, 1'b0);
        err_on_run = 0;
        chk("se_err", 32'(last_err), 32'd1);
        chk("se_count", 32'(log_q.size()), 32'd4);
        chk("se_stop", {23'd0, log_q[3].a, log_q[3].d}, 32'h0100);
        chk("se_no_tsr", 32'(has_tsr_read()), 32'd0);

        // abort during GAP, with a stray command while busy
        base = done_cnt;
        log_q.delete();
        issue(8'h00, 2'b11, 1'b0);
        for (int i = 0; i < 200 && !has_tsr_read(); i++) @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        chk("ab_in_gap", {30'd0, m_psel, busy}, 32'd1);
        cmd_abort = 1'b1;
        cmd_valid = 1'b1;
        @(negedge pclk);
        chk("ab_busy_not_ready", 32'(cmd_ready), 32'd0);
        @(posedge pclk);
        #1;
        cmd_abort = 1'b0;
        cmd_valid = 1'b0;
        wait_done(base);
        n = log_q.size();
        chk("ab_err", 32'(last_err), 32'd1);
        chk("ab_stop", {23'd0, log_q[n-1].a, log_q[n-1].d}, 32'h0100);
        chk("ab_ready_after", 32'(cmd_ready), 32'd1);

`ifdef TIMER_SEQ_TIMEOUT_EN
        tsr_stuck = 1;
        session(8'hF0, 2'b00, 1'b0);
        tsr_stuck = 0;
        run_cyc  = 0;
        stop_cyc = 0;
        foreach (log_q[i]) begin
            if (log_q[i].a == 8'h01 && log_q[i].d == 8'h10) run_cyc = log_q[i].cyc;
            if (log_q[i].a == 8'h01 && log_q[i].d == 8'h00) stop_cyc = log_q[i].cyc;
        end
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_window", 32'((stop_cyc - run_cyc) >= 64 &&
                              (stop_cyc - run_cyc) <= 80), 32'd1);
`else
        run_cyc  = 0;
        stop_cyc = 0;
`endif

        // reset in the middle of a transfer
        issue(8'h20, 2'b00, 1'b0);
        saw = 0;
        for (int i = 0; i < 50 && !saw; i++) begin
            @(posedge pclk);
            #1;
            saw = m_psel;
        end
        chk("pr_psel_seen", 32'(saw), 32'd1);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("pr_bus_idle", {29'd0, m_psel, m_penable, busy}, 32'd0);
        chk("pr_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(posedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_apb_sequencer.md
Name: timer_apb_sequencer

Overview:
- APB master controller that runs complete timer sessions on the 8-bit APB timer without CPU involvement.
- Accepts one command: load value, clock divider and direction.
- Programs TDR and TCR, starts the count, then polls TSR until overflow (up) or underflow (down).
- Clears the flag, stops the timer and reports completion. Sits between the system event logic and the timer's APB slave port.

Parameters:
- POLL_GAP, 4, idle cycles between consecutive TSR reads (0 = back-to-back).
- TIMEOUT_CYCLES, 8192, poll budget in pclk cycles; used only with the optional feature.

Ports:
- pclk  in  1  clock.
- preset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_load  in  8  value written to TDR.
- cmd_cks  in  2  TCR[1:0]: 00 PCLK/2, 01 /4, 10 /8, 11 /16.
- cmd_down  in  1  1 = count down (TCR[5]), 0 = count up.
- cmd_abort  in  1  terminate the session after the current APB transfer.
- done  out  1  one-cycle pulse when a session ends.
- err  out  1  valid with done: pslverr, abort or timeout.
- busy  out  1  high whenever the state is not IDLE.
- m_paddr  out  8  APB address.
- m_psel  out  1  APB select.
- m_penable  out  1  APB enable.
- m_pwrite  out  1  APB write.
- m_pwdata  out  8  APB write data.
- m_prdata  in  8  APB read data.
- m_pready  in  1  APB ready.
- m_pslverr  in  1  APB slave error.

Behaviour:
- Timer map:
  - TDR = 0x00.
  - TCR = 0x01: bit7 load, bit5 down, bit4 enable, bits1:0 cks.
  - TSR = 0x02: bit0 overflow, bit1 underflow; write 0 to clear.
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - State IDLE; latched command cleared.
- Command acceptance: on cmd_valid & cmd_ready, latch cmd_load, cmd_cks and cmd_down. cmd_ready falls on the next cycle.
- State sequence: IDLE -> WR_TDR -> WR_LOAD -> WR_RUN -> POLL -> (GAP -> POLL)* -> CLR -> STOP -> IDLE.
- Writes issued per state:
  - WR_TDR: write 0x00 <= load.
  - WR_LOAD: write 0x01 <= {1, 0, down, 0, 00, cks}.
  - WR_RUN: write 0x01 <= {0, 0, down, 1, 00, cks}.
  - POLL: read 0x02.
  - CLR: write 0x02 <= 0x00.
  - STOP: write 0x01 <= 0x00.
- APB transfer timing:
  - SETUP cycle: psel = 1, penable = 0; address, write and wdata stable.
  - ACCESS cycle: penable = 1. Held until pready.
  - Completion: psel and penable both drop in the cycle after pready.
  - Minimum 2 cycles per transfer; no back-to-back ACCESS without SETUP.
- POLL exit:
  - Target flag is TSR bit0 when up, bit1 when down, sampled at prdata with pready.
  - Flag set -> go to CLR.
  - Flag clear -> go to GAP for POLL_GAP cycles, then POLL again. With POLL_GAP = 0, go directly to POLL.
- Error path:
  - pslverr on any transfer, or cmd_abort seen at any time during a session, sets a sticky abort flag.
  - The current transfer completes; the FSM then jumps to STOP; STOP is always issued.
  - pslverr during STOP itself still ends the session.
- Session end:
  - done pulses one cycle after the STOP transfer completes.
  - err = abort flag, valid in the same cycle as done.
  - The FSM returns to IDLE in the same cycle; cmd_ready = 1 on the next cycle.
- cmd_valid while busy is ignored (not queued).
- preset mid-transfer: psel and penable go 0 on the next edge and the FSM goes to IDLE. The timer is left in its current state; software restarts.
- Counters:
  - Gap counter: 8-bit, saturating.
  - Timeout counter: 16-bit.

Optional Feature:
- Macro: TIMER_SEQ_TIMEOUT_EN.
- Enabled:
  - Cycle counter cleared on entry to WR_RUN, incremented each cycle in POLL/GAP.
  - Reaching TIMEOUT_CYCLES sets the abort flag and goes to STOP; the session ends with err = 1.
- Disabled: no counter; polling continues indefinitely unless cmd_abort or pslverr.

Test Plan:
- Count up, cmd_load = 0xF0, cmd_cks = 00, pready = 1:
  - Writes are 0x00<=F0, 0x01<=0x80, 0x01<=0x10.
  - Polls continue until TSR = 0x01, then 0x02<=00 and 0x01<=00.
  - done = 1, err = 0; CNT = 0x00 after overflow.
- Count down, cmd_load = 0x10, cmd_cks = 11: WR_LOAD = 0xA3, WR_RUN = 0x33; exit on TSR bit1; done with err = 0.
- pready held low 3 cycles on WR_TDR: penable held 4 cycles; address/wdata stable; no state advance until pready.
- pslverr on WR_RUN: next transfer is STOP write 0x01<=00; done with err = 1; no TSR read issued.
- cmd_abort during GAP: STOP issued; done and err = 1. cmd_valid while busy is ignored; cmd_ready returns 1 after done.
- TIMER_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 64, TSR stuck at 0x00: STOP follows about 64 cycles after WR_RUN; done with err = 1.
